// File: rtl/decode_pkg.sv
// Shared encodings for the RV32I decode stage: opcodes, ALU function codes,
// immediate-select codes and the output register state type.
package decode_pkg;

  localparam int ALU_FUN_W_DEF = 4;
  localparam int IMM_SEL_W_DEF = 3;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_NOP = 7'b0000000;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_XOR   = 4'd3;
  localparam logic [3:0] ALU_OR    = 4'd4;
  localparam logic [3:0] ALU_SLL   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_SLT   = 4'd8;
  localparam logic [3:0] ALU_SLTU  = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_U = 3'b011;

  typedef enum logic {
    S_EMPTY,
    S_FULL
  } out_state_e;

  // funct3 -> ALU code; alt selects sub (R-type only) and sra
  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3,
                                             input logic       alt,
                                             input logic       is_r);
    logic [3:0] fun;
    case (f3)
      3'b000:  fun = (is_r && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  fun = ALU_SLL;
      3'b010:  fun = ALU_SLT;
      3'b011:  fun = ALU_SLTU;
      3'b100:  fun = ALU_XOR;
      3'b101:  fun = alt ? ALU_SRA : ALU_SRL;
      3'b110:  fun = ALU_OR;
      default: fun = ALU_AND;
    endcase
    return fun;
  endfunction

endpackage

// File: rtl/inst_decoder.sv
// Pure combinational RV32I subset decoder: instruction word to execute
// control fields plus register-usage flags for the hazard check.
module inst_decoder
  import decode_pkg::*;
#(
  parameter int ALU_FUN_W = ALU_FUN_W_DEF,
  parameter int IMM_SEL_W = IMM_SEL_W_DEF
) (
  input  logic [31:0]          inst_i,
  output logic                 wen_o,
  output logic [IMM_SEL_W-1:0] imm_sel_o,
  output logic                 alu_sel_o,
  output logic [ALU_FUN_W-1:0] alu_fun_o,
  output logic                 illegal_o,
  output logic                 uses_rs1_o,
  output logic                 uses_rs2_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       shift_bad;
  logic       unused_fields;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];
  assign funct7 = inst_i[31:25];
  assign unused_fields = ^{inst_i[24:15], inst_i[11:7]};

  assign shift_bad = ((funct3 == 3'b001) || (funct3 == 3'b101)) &&
                     !((funct7 == 7'b0000000) || (funct7 == 7'b0100000));

  always_comb begin
    wen_o      = 1'b0;
    imm_sel_o  = IMM_SEL_W'(IMM_I);
    alu_sel_o  = 1'b0;
    alu_fun_o  = ALU_FUN_W'(ALU_ADD);
    illegal_o  = 1'b0;
    uses_rs1_o = 1'b0;
    uses_rs2_o = 1'b0;
    case (opcode)
      OP_R: begin
        alu_fun_o = ALU_FUN_W'(alu_from_f3(funct3, funct7[5], 1'b1));
        if (shift_bad) begin
          illegal_o = 1'b1;
        end else begin
          wen_o      = 1'b1;
          uses_rs1_o = 1'b1;
          uses_rs2_o = 1'b1;
        end
      end
      OP_I: begin
        alu_sel_o = 1'b1;
        alu_fun_o = ALU_FUN_W'(alu_from_f3(funct3, funct7[5], 1'b0));
        if (shift_bad) begin
          illegal_o = 1'b1;
        end else begin
          wen_o      = 1'b1;
          uses_rs1_o = 1'b1;
        end
      end
      OP_LUI: begin
        wen_o     = 1'b1;
        alu_sel_o = 1'b1;
        imm_sel_o = IMM_SEL_W'(IMM_U);
        alu_fun_o = ALU_FUN_W'(ALU_PASSB);
      end
      OP_NOP: ;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage with valid/ready handshake and a RAW scoreboard
// that stalls readers of registers still in flight to writeback.
module decode_stage
  import decode_pkg::*;
#(
  parameter int ALU_FUN_W = ALU_FUN_W_DEF,
  parameter int IMM_SEL_W = IMM_SEL_W_DEF,
  parameter int NUM_REGS  = 32,
  parameter bit EN_HAZARD = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 inst_valid_i,
  input  logic [31:0]          inst_i,
  output logic                 inst_ready_o,
  output logic                 dec_valid_o,
  input  logic                 dec_ready_i,
  output logic                 regfile_wen_o,
  output logic [4:0]           rd_o,
  output logic [4:0]           rs1_o,
  output logic [4:0]           rs2_o,
  output logic [IMM_SEL_W-1:0] imm_ext_sel_o,
  output logic                 alu_sel_o,
  output logic [ALU_FUN_W-1:0] alu_fun_o,
  output logic                 illegal_o,
  input  logic                 wb_valid_i,
  input  logic [4:0]           wb_rd_i
);

  logic                 wen_d;
  logic [IMM_SEL_W-1:0] imm_d;
  logic                 alu_sel_d;
  logic [ALU_FUN_W-1:0] fun_d;
  logic                 illegal_d;
  logic                 uses_rs1;
  logic                 uses_rs2;
  logic [4:0]           rd_d;
  logic [4:0]           rs1_d;
  logic [4:0]           rs2_d;

  logic [NUM_REGS-1:0]  pending_q;
  logic                 hazard;
  logic                 accept;
  out_state_e           state_q;
  out_state_e           state_d;

  assign rd_d  = inst_i[11:7];
  assign rs1_d = inst_i[19:15];
  assign rs2_d = inst_i[24:20];

  inst_decoder #(
    .ALU_FUN_W (ALU_FUN_W),
    .IMM_SEL_W (IMM_SEL_W)
  ) u_inst_decoder (
    .inst_i     (inst_i),
    .wen_o      (wen_d),
    .imm_sel_o  (imm_d),
    .alu_sel_o  (alu_sel_d),
    .alu_fun_o  (fun_d),
    .illegal_o  (illegal_d),
    .uses_rs1_o (uses_rs1),
    .uses_rs2_o (uses_rs2)
  );

  assign dec_valid_o  = (state_q == S_FULL);
  assign inst_ready_o = ~rst_i & ~flush_i & (~dec_valid_o | dec_ready_i) & ~hazard;
  assign accept       = inst_valid_i & inst_ready_o;

  generate
    if (EN_HAZARD) begin : g_scoreboard
      assign hazard = inst_valid_i &
                      ((uses_rs1 & pending_q[rs1_d]) | (uses_rs2 & pending_q[rs2_d]));

      // Set has priority over a same-edge writeback clear; bit 0 stays 0.
      always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
          pending_q <= '0;
        end else begin
          for (int unsigned i = 1; i < NUM_REGS; i++) begin
            if (accept && wen_d && (rd_d == 5'(i))) begin
              pending_q[i] <= 1'b1;
            end else if (wb_valid_i && (wb_rd_i == 5'(i))) begin
              pending_q[i] <= 1'b0;
            end
          end
        end
      end
    end else begin : g_no_scoreboard
      logic unused_sb;
      assign pending_q = '0;
      assign hazard    = 1'b0;
      assign unused_sb = ^{wb_valid_i, wb_rd_i, uses_rs1, uses_rs2, pending_q};
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: if (accept) state_d = S_FULL;
        S_FULL:  if (dec_ready_i && !accept) state_d = S_EMPTY;
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      regfile_wen_o <= 1'b0;
      rd_o          <= '0;
      rs1_o         <= '0;
      rs2_o         <= '0;
      imm_ext_sel_o <= '0;
      alu_sel_o     <= 1'b0;
      alu_fun_o     <= '0;
      illegal_o     <= 1'b0;
    end else if (accept) begin
      regfile_wen_o <= wen_d;
      rd_o          <= rd_d;
      rs1_o         <= rs1_d;
      rs2_o         <= rs2_d;
      imm_ext_sel_o <= imm_d;
      alu_sel_o     <= alu_sel_d;
      alu_fun_o     <= fun_d;
      illegal_o     <= illegal_d;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode sweep, backpressure, RAW stalls,
// same-edge scoreboard set/clear, flush, and a hazard-disabled build.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        inst_valid_i;
  logic [31:0] inst_i;
  logic        dec_ready_i;
  logic        wb_valid_i;
  logic [4:0]  wb_rd_i;

  logic        inst_ready_o;
  logic        dec_valid_o;
  logic        regfile_wen_o;
  logic [4:0]  rd_o;
  logic [4:0]  rs1_o;
  logic [4:0]  rs2_o;
  logic [2:0]  imm_ext_sel_o;
  logic        alu_sel_o;
  logic [3:0]  alu_fun_o;
  logic        illegal_o;

  logic        nh_inst_ready;
  logic        nh_dec_valid;
  logic        nh_wen;
  logic [4:0]  nh_rd;
  logic [4:0]  nh_rs1;
  logic [4:0]  nh_rs2;
  logic [2:0]  nh_imm;
  logic        nh_alu_sel;
  logic [3:0]  nh_fun;
  logic        nh_illegal;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  decode_stage #(
    .ALU_FUN_W (4),
    .IMM_SEL_W (3),
    .NUM_REGS  (32),
    .EN_HAZARD (1'b1)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .flush_i       (flush_i),
    .inst_valid_i  (inst_valid_i),
    .inst_i        (inst_i),
    .inst_ready_o  (inst_ready_o),
    .dec_valid_o   (dec_valid_o),
    .dec_ready_i   (dec_ready_i),
    .regfile_wen_o (regfile_wen_o),
    .rd_o          (rd_o),
    .rs1_o         (rs1_o),
    .rs2_o         (rs2_o),
    .imm_ext_sel_o (imm_ext_sel_o),
    .alu_sel_o     (alu_sel_o),
    .alu_fun_o     (alu_fun_o),
    .illegal_o     (illegal_o),
    .wb_valid_i    (wb_valid_i),
    .wb_rd_i       (wb_rd_i)
  );

  decode_stage #(
    .ALU_FUN_W (4),
    .IMM_SEL_W (3),
    .NUM_REGS  (32),
    .EN_HAZARD (1'b0)
  ) dut_nh (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .flush_i       (flush_i),
    .inst_valid_i  (inst_valid_i),
    .inst_i        (inst_i),
    .inst_ready_o  (nh_inst_ready),
    .dec_valid_o   (nh_dec_valid),
    .dec_ready_i   (dec_ready_i),
    .regfile_wen_o (nh_wen),
    .rd_o          (nh_rd),
    .rs1_o         (nh_rs1),
    .rs2_o         (nh_rs2),
    .imm_ext_sel_o (nh_imm),
    .alu_sel_o     (nh_alu_sel),
    .alu_fun_o     (nh_fun),
    .illegal_o     (nh_illegal),
    .wb_valid_i    (wb_valid_i),
    .wb_rd_i       (wb_rd_i)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i        = 1'b1;
    flush_i      = 1'b0;
    inst_valid_i = 1'b0;
    wb_valid_i   = 1'b0;
    wb_rd_i      = '0;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  // Present ins until accepted (bounded), return just after the accept edge.
  task automatic send(input string tag, input logic [31:0] ins);
    int w;
    w = 0;
    inst_i       = ins;
    inst_valid_i = 1'b1;
    #1;
    while (!inst_ready_o && w < 20) begin
      tick();
      w++;
    end
    check(tag, 32'(inst_ready_o), 32'd1);
    tick();
    inst_valid_i = 1'b0;
  endtask

  logic [31:0] sw_inst [6] = '{32'h003100B3, 32'h403100B3, 32'h40335293,
                               32'h00313233, 32'h123453B7, 32'h0000007F};
  logic [3:0]  sw_fun  [6] = '{4'd0, 4'd1, 4'd7, 4'd9, 4'd10, 4'd0};
  logic        sw_sel  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic        sw_wen  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [2:0]  sw_imm  [6] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd3, 3'd0};
  logic        sw_ill  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [4:0]  sw_rd   [6] = '{5'd1, 5'd1, 5'd5, 5'd4, 5'd7, 5'd0};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a valid instruction waiting
    rst_i        = 1'b1;
    flush_i      = 1'b0;
    inst_valid_i = 1'b1;
    inst_i       = 32'h003100B3;
    dec_ready_i  = 1'b1;
    wb_valid_i   = 1'b0;
    wb_rd_i      = '0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst.ready", 32'(inst_ready_o), 32'd0);
      check("rst.valid", 32'(dec_valid_o), 32'd0);
    end
    check("rst.payload", {13'd0, regfile_wen_o, rd_o, rs1_o, rs2_o, imm_ext_sel_o,
                          alu_sel_o, alu_fun_o, illegal_o}, 32'd0);
    inst_valid_i = 1'b0;
    rst_i        = 1'b0;
    tick();
    check("rst.noacc", 32'(dec_valid_o), 32'd0);

    // Decode sweep, full throughput
    for (int i = 0; i < 6; i++) begin
      send("sw.acc", sw_inst[i]);
      check("sw.valid", 32'(dec_valid_o), 32'd1);
      check("sw.fun", 32'(alu_fun_o), 32'(sw_fun[i]));
      check("sw.sel", 32'(alu_sel_o), 32'(sw_sel[i]));
      check("sw.wen", 32'(regfile_wen_o), 32'(sw_wen[i]));
      check("sw.imm", 32'(imm_ext_sel_o), 32'(sw_imm[i]));
      check("sw.ill", 32'(illegal_o), 32'(sw_ill[i]));
      check("sw.rd", 32'(rd_o), 32'(sw_rd[i]));
    end
    tick();
    check("sw.drain", 32'(dec_valid_o), 32'd0);

    // Backpressure
    do_reset();
    dec_ready_i = 1'b0;
    send("bp.acc", 32'h003100B3);
    inst_i       = 32'h00100193;
    inst_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp.ready", 32'(inst_ready_o), 32'd0);
      check("bp.valid", 32'(dec_valid_o), 32'd1);
      check("bp.rd", 32'(rd_o), 32'd1);
      check("bp.sel", 32'(alu_sel_o), 32'd0);
      tick();
    end
    dec_ready_i = 1'b1;
    #1;
    check("bp.release", 32'(inst_ready_o), 32'd1);
    tick();
    inst_valid_i = 1'b0;
    check("bp.next.valid", 32'(dec_valid_o), 32'd1);
    check("bp.next.rd", 32'(rd_o), 32'd3);
    check("bp.next.sel", 32'(alu_sel_o), 32'd1);

    // RAW stall released the cycle after writeback
    do_reset();
    dec_ready_i = 1'b1;
    send("raw.w1", 32'h00500093);
    inst_i       = 32'h00108133;
    inst_valid_i = 1'b1;
    #1;
    check("raw.stall0", 32'(inst_ready_o), 32'd0);
    check("raw.nh.ready", 32'(nh_inst_ready), 32'd1);
    tick();
    check("raw.stall1", 32'(inst_ready_o), 32'd0);
    tick();
    wb_valid_i = 1'b1;
    wb_rd_i    = 5'd1;
    #1;
    check("raw.wbedge", 32'(inst_ready_o), 32'd0);
    tick();
    wb_valid_i = 1'b0;
    #1;
    check("raw.release", 32'(inst_ready_o), 32'd1);
    tick();
    inst_valid_i = 1'b0;
    check("raw.rd", 32'(rd_o), 32'd2);
    inst_i       = 32'h00100193;
    inst_valid_i = 1'b1;
    #1;
    check("raw.x0src", 32'(inst_ready_o), 32'd1);
    tick();
    send("raw.x0dst", 32'h00100013);
    inst_i       = 32'h000002B3;
    inst_valid_i = 1'b1;
    #1;
    check("raw.x0read", 32'(inst_ready_o), 32'd1);
    tick();
    inst_valid_i = 1'b0;

    // Same-edge set and clear of x4: set wins
    do_reset();
    dec_ready_i = 1'b1;
    send("same.w1", 32'h00100213);
    inst_i       = 32'h00200213;
    inst_valid_i = 1'b1;
    wb_valid_i   = 1'b1;
    wb_rd_i      = 5'd4;
    #1;
    check("same.acc", 32'(inst_ready_o), 32'd1);
    tick();
    wb_valid_i = 1'b0;
    inst_i     = 32'h00020333;
    #1;
    check("same.stall0", 32'(inst_ready_o), 32'd0);
    check("same.nh", 32'(nh_inst_ready), 32'd1);
    tick();
    check("same.stall1", 32'(inst_ready_o), 32'd0);
    wb_valid_i = 1'b1;
    wb_rd_i    = 5'd4;
    tick();
    wb_valid_i = 1'b0;
    #1;
    check("same.release", 32'(inst_ready_o), 32'd1);
    tick();
    inst_valid_i = 1'b0;
    check("same.rd", 32'(rd_o), 32'd6);

    // Flush drops held payload and clears scoreboard
    do_reset();
    dec_ready_i = 1'b0;
    send("fl.w1", 32'h00500093);
    check("fl.held", 32'(dec_valid_o), 32'd1);
    inst_i       = 32'h00108133;
    inst_valid_i = 1'b1;
    flush_i      = 1'b1;
    #1;
    check("fl.noacc", 32'(inst_ready_o), 32'd0);
    tick();
    flush_i = 1'b0;
    check("fl.valid", 32'(dec_valid_o), 32'd0);
    #1;
    check("fl.ready", 32'(inst_ready_o), 32'd1);
    tick();
    inst_valid_i = 1'b0;
    check("fl.acc.valid", 32'(dec_valid_o), 32'd1);
    check("fl.acc.rd", 32'(rd_o), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
